time_set_ctrl: RTL and testbench



---
 rtl/time_set_pkg.sv | 20 ++
 rtl/wrap_counter.sv | 41 ++++
 rtl/time_set_ctrl.sv | 128 ++++++++++++
 tb/tb_time_set_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared definitions for the clock mode/time-setting controller:
// FSM state encodings, field widths and field wrap limits.
package time_set_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    localparam int unsigned HOUR_W   = 5;
    localparam int unsigned MIN_W    = 6;
    localparam int unsigned SEC_W    = 6;

    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned SEC_MAX  = 59;

endpackage

// File: rtl/wrap_counter.sv
// Modulo (MAX+1) up/down counter used for one time field.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (value -> 0)
//   up, down    - step requests; both together leave the value unchanged
//   value       - registered field value, 0..MAX
//   carry_out   - combinational: high when this cycle's up wraps MAX -> 0
module wrap_counter #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned MAX   = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] value,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);

    logic step_up;
    logic step_dn;

    assign step_up   = up && !down;
    assign step_dn   = down && !up;

    // Same-cycle carry so a chained neighbour steps on the same edge.
    assign carry_out = step_up && (value == TOP);

    // Field register with wrap in both directions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (step_up) begin
            value <= (value == TOP) ? '0 : value + WIDTH'(1);
        end else if (step_dn) begin
            value <= (value == '0) ? TOP : value - WIDTH'(1);
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Mode and time-setting controller for the electronic clock.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   tick_1hz     - one-cycle pulse per second (counts time in RUN)
//   mode_pulse   - one-cycle mode event: RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN
//   inc_pulse    - one-cycle event: +1 on the edited field (SET states only)
//   dec_pulse    - one-cycle event: -1 on the edited field (SET states only)
//   state        - 0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC
//   hour/min/sec - current time
//   blink_on     - 1 = edited field visible, 0 = blanked
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1hz,
    input  logic              mode_pulse,
    input  logic              inc_pulse,
    input  logic              dec_pulse,
    output logic [1:0]        state,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  min,
    output logic [SEC_W-1:0]  sec,
    output logic              blink_on
);

    localparam int unsigned CNT_W = $clog2(BLINK_DIV);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;

    logic in_run;
    logic inc_acc, dec_acc, edit;
    logic sec_up, sec_dn, min_up, min_dn, hr_up, hr_dn;
    logic sec_carry, min_carry, hr_carry;

    // A mode event swallows inc/dec; inc with dec cancels out.
    assign in_run  = (state_q == ST_RUN);
    assign inc_acc = inc_pulse && !dec_pulse && !mode_pulse;
    assign dec_acc = dec_pulse && !inc_pulse && !mode_pulse;
    assign edit    = !in_run && (inc_acc || dec_acc);

    // RUN: tick into sec with carries chained upward. SET: only the selected field moves.
    assign sec_up = in_run ? tick_1hz  : ((state_q == ST_SET_SEC) && inc_acc);
    assign sec_dn = !in_run && (state_q == ST_SET_SEC) && dec_acc;
    assign min_up = in_run ? sec_carry : ((state_q == ST_SET_MIN) && inc_acc);
    assign min_dn = !in_run && (state_q == ST_SET_MIN) && dec_acc;
    assign hr_up  = in_run ? min_carry : ((state_q == ST_SET_HR) && inc_acc);
    assign hr_dn  = !in_run && (state_q == ST_SET_HR) && dec_acc;

    wrap_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk       (clk),
        .rst_n     (rst_n),
        .up        (sec_up),
        .down      (sec_dn),
        .value     (sec),
        .carry_out (sec_carry)
    );

    wrap_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk       (clk),
        .rst_n     (rst_n),
        .up        (min_up),
        .down      (min_dn),
        .value     (min),
        .carry_out (min_carry)
    );

    // Hour wrap at 23:59:59 needs no further carry.
    wrap_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk       (clk),
        .rst_n     (rst_n),
        .up        (hr_up),
        .down      (hr_dn),
        .value     (hour),
        .carry_out (hr_carry)
    );

    // State, blink counter and blink flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            blink_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    // Next-state sequencing and blink generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;

        case (state_q)
            ST_RUN:     if (mode_pulse) state_d = ST_SET_HR;
            ST_SET_HR:  if (mode_pulse) state_d = ST_SET_MIN;
            ST_SET_MIN: if (mode_pulse) state_d = ST_SET_SEC;
            ST_SET_SEC: if (mode_pulse) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase

        // Restart the blink phase visible whenever the user acts.
        if (in_run || (state_d != state_q) || edit) begin
            cnt_d   = '0;
            blink_d = 1'b1;
        end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            blink_d = !blink_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    assign state    = state_q;
    assign blink_on = blink_q;

    // The hour carry has no consumer.
    logic unused_ok;
    assign unused_ok = hr_carry;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl (BLINK_DIV = 4).
module tb_time_set_ctrl;

    typedef struct packed {
        logic [1:0] st;
        logic [4:0] hr;
        logic [5:0] mn;
        logic [5:0] sc;
        logic       bl;
    } obs_t;

    typedef struct {
        logic tick;
        logic mode;
        logic inc;
        logic dec;
        obs_t exp;
    } vec_t;

    localparam int NROWS = 23;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz, mode_pulse, inc_pulse, dec_pulse;
    logic [1:0] state;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       blink_on;

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t exp_q[$];
    obs_t got;
    vec_t tbl[NROWS];

    time_set_ctrl #(.BLINK_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .mode_pulse (mode_pulse),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .state      (state),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .blink_on   (blink_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb got = {state, hour, min, sec, blink_on};

    function automatic obs_t mk(input int st, input int hr, input int mn, input int sc, input int bl);
        obs_t o;
        o.st = 2'(st);
        o.hr = 5'(hr);
        o.mn = 6'(mn);
        o.sc = 6'(sc);
        o.bl = 1'(bl);
        return o;
    endfunction

    // Blink level k idle cycles after a restart, half-period of 4.
    function automatic int bexp(input int k);
        return (((k / 4) % 2) == 0) ? 1 : 0;
    endfunction

    task automatic compare(input string nm);
        obs_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = exp_q.pop_front();
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got st=%0d %0d:%0d:%0d blink=%0d, want st=%0d %0d:%0d:%0d blink=%0d",
                     nm, got.st, got.hr, got.mn, got.sc, got.bl, e.st, e.hr, e.mn, e.sc, e.bl);
        end
    endtask

    task automatic check_now(input obs_t e, input string nm);
        exp_q.push_back(e);
        compare(nm);
    endtask

    // Drive one cycle of events, expect the result right after the edge.
    task automatic step(input logic t, input logic m, input logic i, input logic d,
                        input obs_t e, input string nm);
        tick_1hz   = t;
        mode_pulse = m;
        inc_pulse  = i;
        dec_pulse  = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        tick_1hz   = 1'b0;
        mode_pulse = 1'b0;
        inc_pulse  = 1'b0;
        dec_pulse  = 1'b0;
        compare(nm);
    endtask

    initial begin
        rst_n      = 1'b0;
        tick_1hz   = 1'b0;
        mode_pulse = 1'b0;
        inc_pulse  = 1'b0;
        dec_pulse  = 1'b0;

        // SET_HR edits, ignored ticks, blink, collisions, then preload 23:59:59.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(1,  0,  1,  1, 1)};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 23,  1,  1, 1)};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1,  0,  1,  1, 1)};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1,  0,  1,  1, 1)};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1,  0,  1,  1, 1)};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, mk(1,  0,  1,  1, 1)};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1,  0,  1,  1, 0)};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(2,  0,  1,  1, 1)};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(2,  0,  0,  1, 1)};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(2,  0, 59,  1, 1)};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(2,  0,  0,  1, 1)};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, mk(3,  0,  0,  1, 1)};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(0,  0,  0,  1, 1)};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(1,  0,  0,  1, 1)};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 23,  0,  1, 1)};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(2, 23,  0,  1, 1)};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(2, 23, 59,  1, 1)};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(3, 23, 59,  1, 1)};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(3, 23, 59,  0, 1)};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(3, 23, 59, 59, 1)};
        tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0, mk(0, 23, 59, 59, 1)};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0,  0,  0,  0, 1)};
        tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0,  0,  0,  1, 1)};

        #12;
        check_now(mk(0, 0, 0, 0, 1), "reset_values");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1), "post_reset_idle");

        // Free-running seconds with the minute carry.
        for (int i = 1; i <= 61; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, i / 60, i % 60, 1), "run_tick");
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 1, 1), "run_inc_ignored");
        step(1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 1, 1, 1), "run_dec_ignored");

        for (int r = 0; r < NROWS; r++)
            step(tbl[r].tick, tbl[r].mode, tbl[r].inc, tbl[r].dec, tbl[r].exp,
                 $sformatf("row%0d", r));

        // Bring min to 30 in SET_MIN, then collisions.
        step(1'b0, 1'b1, 1'b0, 1'b0, mk(1, 0, 0, 1, 1), "to_set_hr");
        step(1'b0, 1'b1, 1'b0, 1'b0, mk(2, 0, 0, 1, 1), "to_set_min");
        for (int i = 1; i <= 30; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, mk(2, 0, i, 1, 1), "min_inc");
        step(1'b0, 1'b0, 1'b1, 1'b1, mk(2, 0, 30, 1, bexp(1)), "inc_dec_cancel");
        step(1'b0, 1'b1, 1'b1, 1'b0, mk(3, 0, 30, 1, 1), "mode_beats_inc");

        // Blink cadence in SET_SEC, then an inc during the blank phase.
        for (int k = 1; k <= 13; k++)
            step(1'b0, 1'b0, 1'b0, 1'b0, mk(3, 0, 30, 1, bexp(k)), "blink_idle");
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(3, 0, 30, 2, 1), "blink_inc_restart");
        for (int k = 1; k <= 5; k++)
            step(1'b0, 1'b0, 1'b0, 1'b0, mk(3, 0, 30, 2, bexp(k)), "blink_after_inc");

        // sec down to 59, back to RUN, then tick+mode.
        step(1'b0, 1'b0, 1'b0, 1'b1, mk(3, 0, 30,  1, 1), "sec_dec");
        step(1'b0, 1'b0, 1'b0, 1'b1, mk(3, 0, 30,  0, 1), "sec_dec");
        step(1'b0, 1'b0, 1'b0, 1'b1, mk(3, 0, 30, 59, 1), "sec_dec_wrap");
        step(1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 30, 59, 1), "back_to_run");
        step(1'b1, 1'b1, 1'b0, 1'b0, mk(1, 0, 31,  0, 1), "tick_and_mode");

        // Park in SET_MIN at 17 with the field blanked, then reset mid-edit.
        step(1'b0, 1'b1, 1'b0, 1'b0, mk(2, 0, 31, 0, 1), "to_set_min2");
        for (int j = 1; j <= 14; j++)
            step(1'b0, 1'b0, 1'b0, 1'b1, mk(2, 0, 31 - j, 0, 1), "min_dec");
        for (int k = 1; k <= 4; k++)
            step(1'b0, 1'b0, 1'b0, 1'b0, mk(2, 0, 17, 0, bexp(k)), "edit_idle");

        #2;
        rst_n = 1'b0;
        #1;
        check_now(mk(0, 0, 0, 0, 1), "async_reset_mid_edit");
        tick_1hz   = 1'b1;
        mode_pulse = 1'b1;
        inc_pulse  = 1'b1;
        @(posedge clk);
        #1;
        check_now(mk(0, 0, 0, 0, 1), "reset_held_with_events");
        tick_1hz   = 1'b0;
        mode_pulse = 1'b0;
        inc_pulse  = 1'b0;
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1), "after_reset_idle");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 1), "after_reset_tick");

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
